// File: rtl/sync_debounce_inputs.sv
// sync_debounce_inputs: per-channel flip-flop synchroniser followed by a
// consecutive-cycle debounce filter with optional bypass. Registered
// rise/fall pulses mark each accepted transition of the debounced level.
module sync_debounce_inputs #(
  parameter int                 WIDTH           = 10,
  parameter int                 SYNC_STAGES     = 2,
  parameter int                 DEBOUNCE_CYCLES = 16,
  parameter logic [WIDTH-1:0]   RESET_VAL       = '0,
  parameter int                 CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  input  logic [WIDTH-1:0] bypass,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  // Terminal count: a differing level is accepted on the edge where the
  // counter already holds DEBOUNCE_CYCLES-1, so it never wraps.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Synchroniser chain, stage 0 samples the raw pins.
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Debounce state per channel.
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [WIDTH-1:0] stable_d, stable_q;
  logic [WIDTH-1:0] rise_d,   rise_q;
  logic [WIDTH-1:0] fall_d,   fall_q;

  // First synchroniser stage captures the asynchronous inputs directly.
  always_comb begin
    sync_d[0] = async_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync_chain
      // Plain stage-to-stage transfer; nothing sits between flops.
      always_comb begin
        sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  // Synchroniser registers, reset to the idle level of each channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Debounce next-state: bypass tracks sync_out, otherwise a level must
  // differ for DEBOUNCE_CYCLES consecutive edges; any match restarts it.
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bypass[i]) begin
        stable_d[i] = sync_out[i];
        cnt_d[i]    = '0;
      end else if (sync_out[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync_out[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      rise_d[i] = stable_d[i] & ~stable_q[i];
      fall_d[i] = ~stable_d[i] & stable_q[i];
    end
  end

  // Debounce registers; pulses land with the first cycle of the new level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q <= RESET_VAL;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_out = stable_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = |(rise_q | fall_q);

endmodule

// File: tb/tb_sync_debounce_inputs.sv
// Bench for sync_debounce_inputs: directed scenarios plus randomized
// traffic, all checked against a queue-based behavioural model.
module tb_sync_debounce_inputs;

  localparam int         W  = 4;
  localparam int         S  = 2;
  localparam int         D  = 4;
  localparam logic [3:0] RV = 4'b0001;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] async_in = 4'b1110;
  logic [3:0] bypass   = 4'b0000;
  logic [3:0] sync_out, stable_out, rise, fall;
  logic       any_change;

  sync_debounce_inputs #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_VAL(RV)
  ) dut (
    .clock(clock), .reset_n(reset_n), .async_in(async_in), .bypass(bypass),
    .sync_out(sync_out), .stable_out(stable_out), .rise(rise), .fall(fall),
    .any_change(any_change)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the synchroniser is a queue of sampled pin words;
  // each channel keeps the list of consecutive pre-edge sync values that
  // disagree with its accepted level, and accepts once D of them exist.
  logic [3:0] m_pipe [$];
  logic [3:0] m_stable, m_rise, m_fall;
  bit         m_hist [W][$];

  task automatic model_reset();
    m_pipe.delete();
    repeat (S) m_pipe.push_back(RV);
    m_stable = RV;
    m_rise   = '0;
    m_fall   = '0;
    for (int i = 0; i < W; i++) m_hist[i].delete();
  endtask

  task automatic model_edge();
    logic [3:0] ms;
    logic       old;
    bit         all_diff;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ms     = m_pipe[$];
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      old = m_stable[i];
      if (bypass[i]) begin
        m_stable[i] = ms[i];
        m_hist[i].delete();
      end else if (ms[i] == m_stable[i]) begin
        m_hist[i].delete();
      end else begin
        m_hist[i].push_back(ms[i]);
        if (m_hist[i].size() >= D) begin
          all_diff = 1'b1;
          for (int j = m_hist[i].size() - D; j < m_hist[i].size(); j++)
            if (m_hist[i][j] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[i] = ms[i];
            m_hist[i].delete();
          end
        end
      end
      m_rise[i] = m_stable[i] & ~old;
      m_fall[i] = ~m_stable[i] & old;
    end
    m_pipe.push_front(async_in);
    void'(m_pipe.pop_back());
  endtask

  task automatic compare_all();
    check("sync",   {28'd0, sync_out},   {28'd0, m_pipe[$]});
    check("stable", {28'd0, stable_out}, {28'd0, m_stable});
    check("rise",   {28'd0, rise},       {28'd0, m_rise});
    check("fall",   {28'd0, fall},       {28'd0, m_fall});
    check("anychg", {31'd0, any_change}, {31'd0, |(m_rise | m_fall)});
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  // Assert reset between edges, check the immediate effect, hold n edges.
  task automatic pulse_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_stable", {28'd0, stable_out}, {28'd0, RV});
    repeat (n) step();
    reset_n = 1'b1;
  endtask

  // Run n edges, counting pulses on one channel and the step of first rise.
  task automatic run_count(input int n, input int ch, output int rises,
                           output int falls, output int first_rise);
    rises = 0; falls = 0; first_rise = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (rise[ch]) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      if (fall[ch]) falls++;
    end
  endtask

  int r, f, fr;

  initial begin
    model_reset();
    // 1: asynchronous reset before any clock edge
    #1 reset_n = 1'b0;
    #1;
    compare_all();
    check("t1_sync",   {28'd0, sync_out},   32'h1);
    check("t1_stable", {28'd0, stable_out}, 32'h1);
    check("t1_pulse",  {28'd0, rise | fall}, 32'h0);
    @(posedge clock); #1;
    async_in = 4'b0001;
    reset_n  = 1'b1;
    repeat (3) step();

    // 2: clean rise on channel 1
    async_in = 4'b0011;
    step();                      // edge 0
    step();                      // edge 1
    check("t2_sync1", {31'd0, sync_out[1]}, 32'h1);
    repeat (3) step();           // edges 2..4
    check("t2_early", {31'd0, stable_out[1]}, 32'h0);
    step();                      // edge 5
    check("t2_stable", {28'd0, stable_out}, 32'h3);
    check("t2_rise",   {28'd0, rise},       32'h2);
    step();                      // edge 6
    check("t2_rise_off", {28'd0, rise}, 32'h0);

    // 3: bounce rejection on channel 1
    async_in = 4'b0001;
    repeat (8) step();
    check("t3_low", {31'd0, stable_out[1]}, 32'h0);
    async_in = 4'b0011;
    repeat (3) step();
    async_in = 4'b0001;
    step();
    async_in = 4'b0011;
    run_count(12, 1, r, f, fr);
    check("t3_rises", r,  32'd1);
    check("t3_when",  fr, 32'd6);

    // 4: simultaneous fall on ch0 and rise on ch3
    pulse_reset(1);
    async_in = 4'b0001;
    repeat (4) step();
    async_in = 4'b1000;
    repeat (5) step();
    check("t4_pre", {31'd0, any_change}, 32'h0);
    step();
    check("t4_rise",   {28'd0, rise},       32'h8);
    check("t4_fall",   {28'd0, fall},       32'h1);
    check("t4_any",    {31'd0, any_change}, 32'h1);
    check("t4_stable", {28'd0, stable_out}, 32'h8);
    step();
    check("t4_any_off", {31'd0, any_change}, 32'h0);

    // 5: bypass on channel 2
    bypass = 4'b0100;
    step();
    async_in = 4'b1100;
    run_count(2, 2, r, f, fr);
    async_in = 4'b1000;
    begin
      int r2, f2, fr2;
      run_count(8, 2, r2, f2, fr2);
      check("t5_rises", r + r2, 32'd1);
      check("t5_falls", f + f2, 32'd1);
    end
    check("t5_others", {28'd0, stable_out}, 32'h8);
    bypass = 4'b0000;
    step();

    // 6: reset in the middle of a count
    pulse_reset(1);
    async_in = 4'b0011;
    repeat (4) step();           // sync differs after edge 1, cnt reaches 2
    pulse_reset(2);
    check("t6_pulses", {28'd0, rise | fall}, 32'h0);
    run_count(8, 1, r, f, fr);
    check("t6_when",  fr, S + D);
    check("t6_rises", r,  32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) async_in = async_in ^ 4'($urandom);
      if ($urandom_range(0, 40) == 0) bypass = 4'($urandom);
      if ($urandom_range(0, 150) == 0) pulse_reset($urandom_range(0, 2));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
